// File: rtl/hazard_unit.sv
// hazard_unit: load-use and branch hazard detection with Mealy stall
// requests, a flush pulse and a saturating stall-cycle counter.
module hazard_unit #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_is_branch,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic              ex_is_load,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              mem_ready,
   input  logic              ex_br_done,
   input  logic              ex_br_taken,
   input  logic              cnt_clr,
   output logic              StallLoad,
   output logic              StallBranch,
   output logic              id_flush,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {RUN, LDWAIT, BRWAIT} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_br_hit;
   logic             w_ld_hit;
   logic             w_rs1_hit;
   logic             w_rs2_hit;
   logic             w_stall;

   assign w_br_hit  = id_valid & id_is_branch;
   assign w_rs1_hit = id_rs1_used & (id_rs1 == ex_rd);
   assign w_rs2_hit = id_rs2_used & (id_rs2 == ex_rd);
   assign w_ld_hit  = id_valid & ex_is_load & (ex_rd != '0)
                    & (w_rs1_hit | w_rs2_hit);

   // Requests are gated by reset so they drop the instant rst falls.
   always_comb begin
      w_next      = r_state;
      StallLoad   = 1'b0;
      StallBranch = 1'b0;
      id_flush    = 1'b0;
      if (rst) begin
         unique case (r_state)
            RUN: begin
               if (w_br_hit) begin
                  StallBranch = 1'b1;
                  w_next      = BRWAIT;
               end else if (w_ld_hit) begin
                  StallLoad = 1'b1;
                  w_next    = LDWAIT;
               end
            end
            LDWAIT: begin
               StallLoad = ~mem_ready;
               if (mem_ready) w_next = RUN;
            end
            BRWAIT: begin
               if (ex_br_done) begin
                  id_flush = ex_br_taken;
                  w_next   = RUN;
               end else begin
                  StallBranch = 1'b1;
               end
            end
            default: w_next = RUN;
         endcase
      end
   end

   assign w_stall = StallLoad | StallBranch;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (cnt_clr)
            r_cnt <= '0;
         else if (w_stall && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and random checks of hazard_unit against
// a flag-based reference model of the hazard rules.
module tb_hazard_unit;

   localparam int AW   = 5;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          id_valid, id_is_branch;
   logic [AW-1:0] id_rs1, id_rs2;
   logic          id_rs1_used, id_rs2_used;
   logic          ex_is_load;
   logic [AW-1:0] ex_rd;
   logic          mem_ready, ex_br_done, ex_br_taken, cnt_clr;
   logic          StallLoad, StallBranch, id_flush;
   logic [CW-1:0] stall_cnt;

   int  n_cmp = 0;
   int  n_bad = 0;
   int  m_cnt;
   bit  m_ldw, m_brw;

   always #5 clk = ~clk;

   hazard_unit #(.REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_is_branch(id_is_branch),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .mem_ready(mem_ready), .ex_br_done(ex_br_done),
      .ex_br_taken(ex_br_taken), .cnt_clr(cnt_clr),
      .StallLoad(StallLoad), .StallBranch(StallBranch),
      .id_flush(id_flush), .stall_cnt(stall_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      id_valid = 0; id_is_branch = 0;
      id_rs1 = 0; id_rs2 = 0;
      id_rs1_used = 0; id_rs2_used = 0;
      ex_is_load = 0; ex_rd = 0;
      mem_ready = 0; ex_br_done = 0; ex_br_taken = 0;
      cnt_clr = 0;
   endtask

   // Called at a falling edge with inputs already applied.
   task automatic cycle();
      bit e_sl, e_sb, e_fl, br, ld;
      if (!rst) begin
         m_ldw = 0; m_brw = 0; m_cnt = 0;
      end
      br = id_valid && id_is_branch;
      ld = id_valid && ex_is_load && (ex_rd != 0) &&
           ((id_rs1_used && id_rs1 == ex_rd) ||
            (id_rs2_used && id_rs2 == ex_rd));
      e_sl = 0; e_sb = 0; e_fl = 0;
      if (rst) begin
         if (m_brw) begin
            e_sb = !ex_br_done;
            e_fl = ex_br_done && ex_br_taken;
         end else if (m_ldw) begin
            e_sl = !mem_ready;
         end else if (br) begin
            e_sb = 1;
         end else if (ld) begin
            e_sl = 1;
         end
      end
      #2;
      chk("StallLoad", StallLoad, e_sl);
      chk("StallBranch", StallBranch, e_sb);
      chk("id_flush", id_flush, e_fl);
      chk("cnt_pre", stall_cnt, m_cnt);
      @(posedge clk);
      if (rst) begin
         if (m_brw) begin
            if (ex_br_done) m_brw = 0;
         end else if (m_ldw) begin
            if (mem_ready) m_ldw = 0;
         end else if (br) begin
            m_brw = 1;
         end else if (ld) begin
            m_ldw = 1;
         end
         if (cnt_clr) m_cnt = 0;
         else if (e_sl || e_sb) m_cnt = (m_cnt + 1 > CMAX) ? CMAX : m_cnt + 1;
      end
      #1;
      chk("cnt_post", stall_cnt, m_cnt);
      @(negedge clk);
   endtask

   initial begin
      rst = 0;
      idle();
      m_cnt = 0; m_ldw = 0; m_brw = 0;
      @(negedge clk);
      id_valid = 1; id_is_branch = 1;
      cycle();
      idle();
      rst = 1;
      cycle();

      // Load-use, memory ready next cycle
      id_valid = 1; ex_is_load = 1; ex_rd = 5;
      id_rs2 = 5; id_rs2_used = 1;
      cycle();
      idle(); mem_ready = 1;
      cycle();
      chk("ldfast_cnt", stall_cnt, 1);
      idle(); cnt_clr = 1;
      cycle();

      // Slow memory: three extra wait cycles
      idle();
      id_valid = 1; ex_is_load = 1; ex_rd = 5;
      id_rs2 = 5; id_rs2_used = 1;
      cycle();
      idle();
      repeat (3) cycle();
      mem_ready = 1;
      cycle();
      chk("ldslow_cnt", stall_cnt, 4);
      idle(); cnt_clr = 1;
      cycle();

      // No false hazards
      idle();
      id_valid = 1; ex_is_load = 1; ex_rd = 0;
      id_rs1 = 0; id_rs1_used = 1;
      cycle();
      ex_rd = 7; id_rs1 = 7; id_rs1_used = 0;
      id_rs2 = 7; id_rs2_used = 0;
      cycle();
      chk("nofalse_cnt", stall_cnt, 0);

      // Branch taken, then not taken
      for (int t = 1; t >= 0; t--) begin
         idle(); id_valid = 1; id_is_branch = 1;
         cycle();
         idle();
         cycle();
         ex_br_done = 1; ex_br_taken = t[0];
         cycle();
         idle();
         cycle();
      end
      chk("branch_cnt", stall_cnt, 4);

      // Branch beats load in the same cycle
      idle();
      id_valid = 1; id_is_branch = 1; ex_is_load = 1;
      ex_rd = 3; id_rs1 = 3; id_rs1_used = 1;
      cycle();
      idle();
      repeat (20) cycle();
      chk("sat_cnt", stall_cnt, CMAX);
      cnt_clr = 1;
      cycle();
      chk("clr_cnt", stall_cnt, 0);

      // Reset dropped mid branch wait with a taken resolution present
      idle();
      ex_br_done = 1; ex_br_taken = 1;
      rst = 0;
      cycle();
      rst = 1;
      cycle();
      chk("rst_noflush", id_flush, 0);
      idle(); id_valid = 1; id_is_branch = 1;
      cycle();
      idle(); ex_br_done = 1; ex_br_taken = 1;
      cycle();

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         id_valid     = ($urandom_range(0, 3) != 0);
         id_is_branch = ($urandom_range(0, 4) == 0);
         id_rs1       = AW'($urandom_range(0, 3));
         id_rs2       = AW'($urandom_range(0, 3));
         id_rs1_used  = 1'($urandom);
         id_rs2_used  = 1'($urandom);
         ex_is_load   = 1'($urandom);
         ex_rd        = AW'($urandom_range(0, 3));
         mem_ready    = 1'($urandom);
         ex_br_done   = ($urandom_range(0, 2) == 0);
         ex_br_taken  = 1'($urandom);
         cnt_clr      = ($urandom_range(0, 29) == 0);
         rst          = ($urandom_range(0, 49) != 0);
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, stall-cycle counter width.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 id_valid  input  1  ID stage holds a real instruction.
REQ-007 id_is_branch  input  1  ID instruction is a branch or jump.
REQ-008 id_rs1, id_rs2  input  REG_AW each  ID source register addresses.
REQ-009 id_rs1_used, id_rs2_used  input  1 each  the source is actually read.
REQ-010 ex_is_load  input  1  EX instruction is a load.
REQ-011 ex_rd  input  REG_AW  EX destination register.
REQ-012 mem_ready  input  1  data memory has returned load data this cycle.
REQ-013 ex_br_done  input  1  single-cycle pulse: the pending branch has resolved in EX.
REQ-014 ex_br_taken  input  1  resolution result; valid only with ex_br_done.
REQ-015 cnt_clr  input  1  synchronous clear of stall_cnt.
REQ-016 StallLoad  output  1  load stall request to the stall controller.
REQ-017 StallBranch  output  1  branch stall request to the stall controller.
REQ-018 id_flush  output  1  invalidate the IF/ID register.
REQ-019 stall_cnt  output  CNT_W  saturating count of stalled cycles.

Function
REQ-020 SHALL implement a 3-state FSM: RUN, LDWAIT, BRWAIT; state and stall_cnt are the only registers.
REQ-021 StallLoad, StallBranch and id_flush SHALL be combinational (Mealy) in current state and inputs, with zero-cycle latency.
REQ-022 br_hit SHALL equal id_valid & id_is_branch.
REQ-023 ld_hit SHALL equal id_valid & ex_is_load & (ex_rd != 0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
REQ-024 RUN with br_hit: StallBranch=1; next state BRWAIT; ld_hit is ignored in that cycle (branch has priority).
REQ-025 RUN with ld_hit and no br_hit: StallLoad=1 for exactly that cycle; next state LDWAIT.
REQ-026 RUN with neither hit: all request outputs 0; stay RUN; ex_br_done and mem_ready are ignored.
REQ-027 LDWAIT: StallLoad = ~mem_ready; on mem_ready=1 go to RUN, else stay.
REQ-028 LDWAIT SHALL NOT evaluate br_hit or ld_hit; new hazards are detected only after returning to RUN.
REQ-029 BRWAIT: StallBranch=1 while ex_br_done=0; stay BRWAIT.
REQ-030 BRWAIT with ex_br_done=1: StallBranch=0; id_flush=ex_br_taken; go to RUN.
REQ-031 id_flush SHALL be 0 in every state and cycle other than those covered by REQ-030.
REQ-032 StallLoad and StallBranch SHALL never both be 1.
REQ-033 stall_cnt SHALL increment by 1 on each clock edge where (StallLoad | StallBranch)=1.
REQ-034 stall_cnt SHALL saturate at all-ones with no wrap-around.
REQ-035 cnt_clr=1 SHALL set stall_cnt to 0 on the next edge; clear has priority over increment.

Reset
REQ-036 While rst=0, state SHALL be RUN and stall_cnt SHALL be 0, asynchronously.
REQ-037 While rst=0, StallLoad, StallBranch and id_flush SHALL be 0 regardless of inputs.
REQ-038 Reset asserted while in LDWAIT or BRWAIT SHALL abandon the wait with no flush pulse.
REQ-039 After rst rises, the FSM SHALL start from RUN on the next clock edge.

Verification
REQ-040 Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_rs2_used=1, mem_ready=1 the next cycle -> StallLoad=1 for 1 cycle, back in RUN, stall_cnt=1.
REQ-041 Slow memory: same stimulus as REQ-040 but mem_ready low for 3 cycles after detection -> StallLoad=1 for 4 cycles total, stall_cnt=4.
REQ-042 No false hazards: ex_rd=0 matching, or matching source with its _used bit=0 -> StallLoad stays 0.
REQ-043 Branch: br_hit, then ex_br_done=1 with ex_br_taken=1 on the 3rd cycle -> StallBranch=1 for 2 cycles, then id_flush=1 for 1 cycle; repeat with ex_br_taken=0 -> id_flush stays 0.
REQ-044 Priority and clear: br_hit and ld_hit in the same cycle -> only StallBranch asserted; force stall_cnt to all-ones, keep a stall active -> stays all-ones; cnt_clr=1 -> 0.
REQ-045 Reset in BRWAIT: drop rst mid-wait -> outputs 0 immediately, no flush pulse, state RUN after release.
